// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the convolution line buffer: accepts a raster pixel stream,
// drives the line buffer shift enable/data, and flags complete KxK windows.
// Optional stall counter output is enabled by defining LB_CTRL_STALL_CNT_EN.
module line_buffer_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned IMG_WIDTH   = 28,
  parameter int unsigned IMG_HEIGHT  = 28,
  parameter int unsigned CW          = $clog2(IMG_WIDTH),
  parameter int unsigned RW          = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  lb_enable,
  output logic [DATA_WIDTH-1:0] lb_data,
  output logic                  win_valid,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  busy,
`ifdef LB_CTRL_STALL_CNT_EN
  output logic [31:0]           stall_cnt,
`endif
  output logic                  done
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] FILL_ROW = RW'(KERNEL_SIZE - 2);
  localparam logic [CW-1:0] K1_COL   = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] K1_ROW   = RW'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_win_valid;
  logic [RW-1:0]   r_win_row;
  logic [CW-1:0]   r_win_col;
  logic            r_busy;
  logic            r_done;
`ifdef LB_CTRL_STALL_CNT_EN
  logic [31:0]     r_stall_cnt;
`endif

  logic w_in_ready;
  logic w_accept;
  logic w_last_col;

  assign w_in_ready = ((r_state == S_FILL) || (r_state == S_RUN)) && !hold;
  assign w_accept   = in_valid && w_in_ready;
  assign w_last_col = (r_col == LAST_COL);

  assign in_ready  = w_in_ready;
  assign lb_enable = w_accept;
  assign lb_data   = in_data;
  assign win_valid = r_win_valid;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;
  assign busy      = r_busy;
  assign done      = r_done;
`ifdef LB_CTRL_STALL_CNT_EN
  assign stall_cnt = r_stall_cnt;
`endif

  // Sequencer, raster counters and the one-cycle-late window flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef LB_CTRL_STALL_CNT_EN
      r_stall_cnt <= '0;
`endif
    end else begin
      r_win_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FILL;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
`ifdef LB_CTRL_STALL_CNT_EN
            r_stall_cnt <= '0;
`endif
          end
        end
        S_FILL, S_RUN: begin
`ifdef LB_CTRL_STALL_CNT_EN
          if (in_valid && hold && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
`endif
          if (w_accept) begin
            if ((r_row >= K1_ROW) && (r_col >= K1_COL)) begin
              r_win_valid <= 1'b1;
              r_win_row   <= r_row - K1_ROW;
              r_win_col   <= r_col - K1_COL;
            end
            if (w_last_col) begin
              r_col <= '0;
              r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            if ((r_state == S_FILL) && w_last_col && (r_row == FILL_ROW))
              r_state <= S_RUN;
            if ((r_state == S_RUN) && w_last_col && (r_row == LAST_ROW)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl (8x8 image, K=3 main DUT, K=8 companion DUT).
// A raster-count reference model checks every cycle; stall counter checked when LB_CTRL_STALL_CNT_EN is set.
module tb_line_buffer_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned K  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned NWIN = (H - K + 1) * (W - K + 1);

  logic          clk = 1'b0;
  logic          rst, start, hold, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, lb_enable, win_valid, busy, done;
  logic [DW-1:0] lb_data;
  logic [2:0]    win_row, win_col;
  logic          in_ready8, lb_enable8, win_valid8, busy8, done8;
  logic [DW-1:0] lb_data8;
  logic [2:0]    win_row8, win_col8;
`ifdef LB_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cnt, stall_cnt8;
`endif

  line_buffer_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .lb_enable(lb_enable), .lb_data(lb_data),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy),
`ifdef LB_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done));

  line_buffer_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .in_valid(in_valid),
    .in_ready(in_ready8), .in_data(in_data), .lb_enable(lb_enable8), .lb_data(lb_data8),
    .win_valid(win_valid8), .win_row(win_row8), .win_col(win_col8), .busy(busy8),
`ifdef LB_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt8),
`endif
    .done(done8));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int frames_done = 0;
  int pix = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame progress as a pixel count; row/col come from div/mod.
  typedef enum int {P_IDLE, P_ACT, P_DONE} phase_t;
  phase_t m_phase = P_IDLE;
  bit     m_ok = 0;
  int     m_n = 0, m_wr = 0, m_wc = 0, cnt_lb = 0, cnt_win = 0;
  bit     m_win = 0, m_done = 0;
  longint m_stall = 0;

  always @(negedge clk) begin
    bit exp_rdy, exp_acc;
    int r, c;
    exp_rdy = (m_phase == P_ACT) && !hold;
    exp_acc = exp_rdy && in_valid;
    if (m_ok) begin
      chk("busy", 64'(busy), 64'(m_phase == P_ACT));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("lb_enable", 64'(lb_enable), 64'(exp_acc));
      chk("done", 64'(done), 64'(m_done));
      chk("win_valid", 64'(win_valid), 64'(m_win));
      chk("win_row", 64'(win_row), 64'(m_wr));
      chk("win_col", 64'(win_col), 64'(m_wc));
      if (exp_acc) chk("lb_data", 64'(lb_data), 64'(m_n));
      chk("k8_done", 64'(done8), 64'(m_done));
      chk("k8_win_valid", 64'(win_valid8), 64'(m_done));
      chk("k8_win_rc", 64'({win_row8, win_col8}), 64'(0));
`ifdef LB_CTRL_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
      if (lb_enable) cnt_lb++;
      if (win_valid) cnt_win++;
      if (done) begin
        chk("frame_lb_pulses", 64'(cnt_lb), 64'(NPIX));
        chk("frame_win_pulses", 64'(cnt_win), 64'(NWIN));
        cnt_lb = 0;
        cnt_win = 0;
        frames_done++;
      end
    end
    if (rst) begin
      m_ok = 1; m_phase = P_IDLE; m_n = 0; m_win = 0; m_done = 0;
      m_wr = 0; m_wc = 0; cnt_lb = 0; cnt_win = 0; m_stall = 0;
    end else begin
      m_win = 0;
      m_done = 0;
      case (m_phase)
        P_IDLE: if (start) begin m_phase = P_ACT; m_n = 0; m_stall = 0; end
        P_DONE: m_phase = P_IDLE;
        default: begin
          if (in_valid && hold && m_stall < 64'hFFFF_FFFF) m_stall++;
          if (exp_acc) begin
            r = m_n / W;
            c = m_n % W;
            if (r >= K - 1 && c >= K - 1) begin
              m_win = 1; m_wr = r - (K - 1); m_wc = c - (K - 1);
            end
            m_n++;
            if (m_n == NPIX) begin m_phase = P_DONE; m_done = 1; end
          end
        end
      endcase
    end
  end

  // One clock of stimulus; pixel value tracks the next pixel the frame should consume.
  task automatic step(input logic st, input logic v, input logic h);
    @(posedge clk);
    #1;
    start = st; in_valid = v; hold = h; in_data = DW'(pix);
    @(negedge clk);
    if (rst) pix = 0;
    else if (in_valid && in_ready) pix = (pix + 1) % NPIX;
  endtask

  task automatic finish_frame(input int vpct, input int hpct, input int spct);
    int fd0;
    fd0 = frames_done;
    for (int i = 0; i < 3000 && frames_done == fd0; i++)
      step(1'($urandom_range(99) < spct), 1'($urandom_range(99) < vpct),
           1'($urandom_range(99) < hpct));
    chk("frame_completed", 64'(frames_done), 64'(fd0 + 1));
  endtask

  typedef struct {
    logic st, v, h;
    logic e_rdy, e_lben, e_busy;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{st:0, v:1, h:0, e_rdy:0, e_lben:0, e_busy:0};
    tbl[1] = '{st:1, v:1, h:0, e_rdy:0, e_lben:0, e_busy:0};
    tbl[2] = '{st:0, v:1, h:1, e_rdy:0, e_lben:0, e_busy:1};
    tbl[3] = '{st:0, v:0, h:0, e_rdy:1, e_lben:0, e_busy:1};
    tbl[4] = '{st:0, v:1, h:0, e_rdy:1, e_lben:1, e_busy:1};
    tbl[5] = '{st:0, v:1, h:1, e_rdy:0, e_lben:0, e_busy:1};
    tbl[6] = '{st:0, v:1, h:0, e_rdy:1, e_lben:1, e_busy:1};

    rst = 1; start = 0; hold = 0; in_valid = 0; in_data = '0;
    repeat (3) step(0, 0, 0);
    rst = 0;
    step(0, 0, 0);
    chk("reset_state", 64'({busy, done, win_valid, win_row, win_col}), 64'(0));

    // Start-up and stall handshake vectors, then the rest of frame 1 at full rate.
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].v, tbl[i].h);
      chk("vec_in_ready", 64'(in_ready), 64'(tbl[i].e_rdy));
      chk("vec_lb_enable", 64'(lb_enable), 64'(tbl[i].e_lben));
      chk("vec_busy", 64'(busy), 64'(tbl[i].e_busy));
    end
    finish_frame(100, 0, 0);

    // Random gaps and holds.
    step(0, 0, 0); step(1, 0, 0);
    finish_frame(70, 30, 0);

    // Stray start pulses while busy.
    step(0, 0, 0); step(1, 1, 0);
    finish_frame(80, 20, 25);

    // Reset in the middle of RUN, then a clean random frame.
    step(0, 0, 0); step(1, 1, 0);
    for (int i = 0; i < 200 && pix != 40; i++) step(0, 1, 0);
    chk("reached_pixel_40", 64'(pix), 64'(40));
    rst = 1;
    step(0, 1, 0);
    rst = 0;
    step(0, 0, 0);
    chk("after_rst_busy_win_done", 64'({busy, win_valid, done}), 64'(0));
    step(1, 0, 0);
    finish_frame(75, 25, 0);

    // Start held high across a frame boundary: back-to-back frames.
    step(0, 0, 0); step(1, 1, 0);
    finish_frame(100, 0, 100);
    finish_frame(100, 0, 0);

`ifdef LB_CTRL_STALL_CNT_EN
    step(0, 0, 0); step(1, 1, 0);
    for (int i = 0; i < 200 && pix < W * (K - 1) + 3; i++) step(0, 1, 0);
    repeat (10) step(0, 1, 1);
    step(0, 0, 0);
    chk("stall_cnt_10", 64'(stall_cnt), 64'(10));
    finish_frame(100, 0, 0);
    chk("stall_cnt_hold_after_done", 64'(stall_cnt), 64'(10));
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("stall_cnt_cleared", 64'(stall_cnt), 64'(0));
    finish_frame(100, 0, 0);
`endif

    repeat (3) step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
